// File: rtl/alarm_set_controller.sv
// rtl/alarm_set_controller.sv - alarm field editing, edge-detected keys and arm/ring sequencing
module alarm_set_controller #(
  parameter int RING_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_key,
  input  logic       right_key,
  input  logic       up_key,
  input  logic       arm_key,
  input  logic       tick_1hz,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  output logic [5:0] alarm_sec,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic [1:0] state,
  output logic       upsec,
  output logic       upmin,
  output logic       uphour,
  output logic       armed,
  output logic       ringing
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2
  } arm_state_t;

  localparam logic [7:0] RING_LIMIT = 8'(RING_SECONDS);

  arm_state_t arm_state;
  logic [7:0] ring_cnt;
  logic       left_q;
  logic       right_q;
  logic       up_q;
  logic       arm_q;
  logic       ready;
  logic       up_req;
  logic [1:0] up_sel;

  logic left_ev;
  logic right_ev;
  logic up_ev;
  logic arm_ev;
  logic match;

  // ready stays low for the first edge after reset so a key held through
  // release loads its history instead of producing an event
  assign left_ev  = ready & left_key  & ~left_q;
  assign right_ev = ready & right_key & ~right_q;
  assign up_ev    = ready & up_key    & ~up_q;
  assign arm_ev   = ready & arm_key   & ~arm_q;

  assign match = tick_1hz && (cur_sec == alarm_sec) && (cur_min == alarm_min)
                 && (cur_hour == alarm_hour);

  always_ff @(posedge clk) begin
    if (!reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      up_q    <= 1'b0;
      arm_q   <= 1'b0;
      ready   <= 1'b0;
    end else begin
      left_q  <= left_key;
      right_q <= right_key;
      up_q    <= up_key;
      arm_q   <= arm_key;
      ready   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= 2'd0;
    end else if (left_ev && !right_ev && state != 2'd2) begin
      state <= state + 2'd1;
    end else if (right_ev && !left_ev && state != 2'd0) begin
      state <= state - 2'd1;
    end
  end

  // Increment is applied one edge after the up event, using the select
  // value captured at the event edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      up_req     <= 1'b0;
      up_sel     <= 2'd0;
      alarm_sec  <= 6'd0;
      alarm_min  <= 6'd0;
      alarm_hour <= 5'd0;
      upsec      <= 1'b0;
      upmin      <= 1'b0;
      uphour     <= 1'b0;
    end else begin
      up_req <= up_ev && (arm_state != RINGING);
      up_sel <= state;
      upsec  <= 1'b0;
      upmin  <= 1'b0;
      uphour <= 1'b0;
      if (up_req) begin
        case (up_sel)
          2'd0: begin
            alarm_sec <= (alarm_sec == 6'd59) ? 6'd0 : alarm_sec + 6'd1;
            upsec     <= 1'b1;
          end
          2'd1: begin
            alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
            upmin     <= 1'b1;
          end
          2'd2: begin
            alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
            uphour     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Arm events take priority over match and over the final ring tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      arm_state <= DISARMED;
      ring_cnt  <= 8'd0;
      armed     <= 1'b0;
      ringing   <= 1'b0;
    end else begin
      case (arm_state)
        DISARMED: begin
          if (arm_ev) begin
            arm_state <= ARMED;
            armed     <= 1'b1;
            ringing   <= 1'b0;
          end
        end
        ARMED: begin
          if (arm_ev) begin
            arm_state <= DISARMED;
            armed     <= 1'b0;
            ringing   <= 1'b0;
          end else if (match) begin
            arm_state <= RINGING;
            ring_cnt  <= 8'd0;
            armed     <= 1'b1;
            ringing   <= 1'b1;
          end
        end
        RINGING: begin
          if (arm_ev) begin
            arm_state <= DISARMED;
            armed     <= 1'b0;
            ringing   <= 1'b0;
          end else if (tick_1hz) begin
            if (ring_cnt + 8'd1 == RING_LIMIT) begin
              arm_state <= ARMED;
              ring_cnt  <= 8'd0;
              armed     <= 1'b1;
              ringing   <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
        default: begin
          arm_state <= DISARMED;
          armed     <= 1'b0;
          ringing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alarm_set_controller.md
Name: alarm_set_controller

Overview:
Sequences the user-facing alarm-setting datapath. It turns raw left/right/up/arm key levels into single-cycle edge events and selects the field being edited (seconds, minutes or hours). It holds the alarm time registers with modular wrap and compares them against the running clock. A small arm/ring state machine drives the ringing output. It sits between the debounced key inputs and the display/time-keeping blocks.

Parameters:
RING_SECONDS, 60, number of tick_1hz pulses the ringing output stays high before automatic stop (1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
left_key  input  1  debounced level, high while pressed; moves field select toward hours
right_key  input  1  debounced level; moves field select toward seconds
up_key  input  1  debounced level; increments selected alarm field
arm_key  input  1  debounced level; toggles armed, stops ringing
tick_1hz  input  1  one-cycle pulse per second from time-keeping block
cur_sec  input  6  current seconds 0..59
cur_min  input  6  current minutes 0..59
cur_hour  input  5  current hours 0..23
alarm_sec  output  6  alarm seconds register
alarm_min  output  6  alarm minutes register
alarm_hour  output  5  alarm hours register
state  output  2  field select: 0=sec, 1=min, 2=hour (3 never driven)
upsec, upmin, uphour  output  1 each  one-cycle pulse coincident with an update of that field
armed  output  1  high in ARMED or RINGING
ringing  output  1  high in RINGING

Behaviour:
- All logic clocked on rising clk; reset sampled low at an edge forces: state=0, alarm_sec/min/hour=0, up* pulses=0, armed=0, ringing=0, ring counter=0, key history registers=0. Reset mid-ring or mid-edit aborts immediately; a key held through reset release produces no event.
- Edge detect: each key has a history flop. An event occurs at edge N when the key is 1 at N and the history is 0. Key held high produces one event only.
- Field select, evaluated on events:
  - left alone: 0->1, 1->2, 2 stays 2.
  - right alone: 2->1, 1->0, 0 stays 0.
  - left and right events in the same cycle: no change.
- Increment, up event while not RINGING:
  - selected field +1 mod 60 (sec, min) or mod 24 (hour); 59->0, 23->0.
  - Uses the select value before any same-cycle left/right update.
  - Field register and matching up* pulse update at edge N+1 after event edge N; pulse lasts exactly one cycle.
  - up events in RINGING are ignored; no pulse.
- Arm/ring FSM, states DISARMED (reset), ARMED, RINGING:
  - DISARMED + arm event -> ARMED.
  - ARMED + arm event -> DISARMED.
  - ARMED + tick_1hz + (cur_sec,cur_min,cur_hour)==(alarm_sec,alarm_min,alarm_hour) -> RINGING; ring counter cleared.
  - ARMED: if an arm event and a match occur in the same cycle, the arm event wins -> DISARMED.
  - RINGING + arm event -> DISARMED.
  - RINGING: each tick_1hz increments the counter; at the tick that makes the count equal RING_SECONDS -> ARMED.
  - RINGING: if an arm event and the final tick occur in the same cycle, the arm event wins -> DISARMED.
  - Comparison uses current register values. An edit that makes the alarm match takes effect from the next tick.
- armed and ringing are registered outputs, decoded from the state register.
- No match without tick_1hz; a match is checked only in ARMED.

Test Plan:
- Reset low 2 cycles with keys held high, release -> all outputs 0, state=0; no events until keys drop and rise again.
- Pulse left 3 times, then right once -> state sequence 1,2,2,1; right again twice -> 0,0; left+right same cycle from 1 -> stays 1.
- state=0, 61 up presses -> alarm_sec=1, upsec pulsed 61 times, each exactly 1 cycle; state=2, 24 presses -> alarm_hour=0 after 23 wraps to 0.
- Alarm 07:30:05, arm, drive cur=07:30:05 with tick -> ringing=1 next cycle; RING_SECONDS=3, three further ticks -> ringing=0, armed=1.
- While ringing, arm press -> ringing=0, armed=0 next cycle; up press while ringing -> alarm unchanged, no upsec.
- While ringing, assert reset low -> all outputs 0 at the next edge; armed stays 0 after release.
